stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: sys_clk frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100: count resolution in Hz (centiseconds); CLK_HZ SHALL be an integer multiple of TICK_HZ.
REQ-003 Parameter MIN_DIGITS, default 2: number of BCD minute digits, range 1..4.
REQ-004 Parameter LAP_DEPTH, default 4: lap store entries, power of two, range 2..16.
REQ-005 Derived width W = 4*(4+MIN_DIGITS), packed {min, sec_tens, sec_ones, cs_tens, cs_ones}, minutes MSB.
REQ-006 Port sys_clk, in, 1: sole clock, rising edge.
REQ-007 Port sys_rst, in, 1: reset, synchronous, active-high.
REQ-008 Port key_start, in, 1: one-cycle pulse that toggles run/stop.
REQ-009 Port key_lap, in, 1: one-cycle pulse that captures the current time into the lap store.
REQ-010 Port key_clear, in, 1: one-cycle pulse that stops, reloads and empties the lap store.
REQ-011 Port count_down, in, 1: mode select (0 up, 1 down), latched only on key_clear.
REQ-012 Port preset_bcd, in, W: countdown start value, loaded on key_clear when count_down=1.
REQ-013 Port lap_sel, in, clog2(LAP_DEPTH): lap index, 0 = most recent.
REQ-014 Port time_bcd, out, W: current time, registered.
REQ-015 Port running, out, 1: counter advancing.
REQ-016 Port expired, out, 1: countdown reached zero; sticky.
REQ-017 Port overflow, out, 1: count-up wrapped past maximum; sticky.
REQ-018 Port lap_bcd, out, W: stored lap at lap_sel, registered.
REQ-019 Port lap_count, out, clog2(LAP_DEPTH)+1: valid laps, saturating at LAP_DEPTH.

Function
REQ-020 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 while running, emit a one-cycle tick at the terminal count, hold when stopped, and zero on clear.
REQ-021 On a tick, time_bcd SHALL update on the next rising edge (1-cycle latency), with BCD carry/borrow cs 99->00, sec 59->00, min (10^MIN_DIGITS-1)->0.
REQ-022 Count-up at maximum: wrap to all-zero, set overflow, keep running.
REQ-023 Count-down reaching zero: running<=0, expired<=1 in the same edge that writes zero.
REQ-024 key_start while stopped in count-down mode with time_bcd=0: ignored.
REQ-025 key_clear: running<=0, expired<=0, overflow<=0, prescaler<=0, lap_count<=0, mode<=count_down, time_bcd<=(count_down ? preset_bcd : 0).
REQ-026 Priority in one cycle: key_clear overrides key_start and key_lap; key_lap + key_start both act, lap storing the pre-edge time_bcd.
REQ-027 key_lap with tick in the same cycle: lap stores the pre-increment value.
REQ-028 Lap store is a circular buffer; when full, a new lap overwrites the oldest; lap_count saturates at LAP_DEPTH.
REQ-029 lap_bcd SHALL reflect lap_sel one cycle later; lap_sel >= lap_count yields all-zero.
REQ-030 key_lap is accepted whether running or stopped.
REQ-031 Changing count_down without key_clear SHALL have no effect.

Reset
REQ-032 sys_rst: time_bcd=0, running=0, expired=0, overflow=0, lap_count=0, lap_bcd=0, prescaler=0, mode=up; all lap entries zeroed.
REQ-033 sys_rst SHALL override all key inputs in the same cycle, including mid-count.

Structure
REQ-034 Package stopwatch_pkg SHALL hold the BCD digit type, field offsets/widths as functions of MIN_DIGITS, and the digit limits (9, 5, 9, 9).
REQ-035 Sub-module sw_bcd_chain: combinational increment/decrement of the packed BCD word with wrap/zero flags; stopwatch_core owns all registers.

Verification
REQ-036 CLK_HZ=1000, TICK_HZ=100, key_start, 250 cycles -> time_bcd cs=25, running=1.
REQ-037 Count-up preloaded via force to 99:59.99, one tick -> time_bcd=00:00.00, overflow=1, running=1.
REQ-038 count_down=1, preset 00:00.03, key_clear, key_start, 30 cycles -> time_bcd=0, expired=1, running=0; then key_start -> running stays 0.
REQ-039 LAP_DEPTH=4, 5 key_lap pulses at times 1..5 cs -> lap_count=4, lap_sel 0..3 -> 5,4,3,2 cs; lap_sel beyond count after clear -> 0.
REQ-040 key_clear and key_lap in the same cycle while running -> lap_count=0, running=0; key_lap with tick -> stored value = pre-tick time.
REQ-041 sys_rst asserted mid-count at 00:12.34 -> next edge all outputs zero, mode=up.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Packed BCD time-word layout and per-digit limits shared by the stopwatch core.
// Digit order, LSB first: cs_ones, cs_tens, sec_ones, sec_tens, minutes.
package stopwatch_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int CS_ONES_LSB  = 0;
  localparam int CS_TENS_LSB  = 4;
  localparam int SEC_ONES_LSB = 8;
  localparam int SEC_TENS_LSB = 12;
  localparam int MIN_LSB      = 16;

  localparam bcd_digit_t CS_ONES_MAX   = 4'd9;
  localparam bcd_digit_t CS_TENS_MAX   = 4'd9;
  localparam bcd_digit_t SEC_ONES_MAX  = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX  = 4'd5;
  localparam bcd_digit_t MIN_DIGIT_MAX = 4'd9;

  function automatic int min_width(input int min_digits);
    return 4 * min_digits;
  endfunction

  function automatic int word_width(input int min_digits);
    return MIN_LSB + min_width(min_digits);
  endfunction

  // Largest legal value of the digit at position idx (0 = cs_ones).
  function automatic bcd_digit_t digit_limit(input int idx);
    bcd_digit_t lim;
    case (4 * idx)
      CS_ONES_LSB:  lim = CS_ONES_MAX;
      CS_TENS_LSB:  lim = CS_TENS_MAX;
      SEC_ONES_LSB: lim = SEC_ONES_MAX;
      SEC_TENS_LSB: lim = SEC_TENS_MAX;
      default:      lim = MIN_DIGIT_MAX;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/sw_bcd_chain.sv
// Combinational +1 / -1 step of the packed BCD time word with ripple carry/borrow.
// wrap flags a carry (or borrow) out of the top digit; next_zero flags an all-zero result.
module sw_bcd_chain
  import stopwatch_pkg::*;
#(
  parameter int MIN_DIGITS = 2
) (
  input  logic [word_width(MIN_DIGITS)-1:0] value,
  input  logic                              down,
  output logic [word_width(MIN_DIGITS)-1:0] next_value,
  output logic                              wrap,
  output logic                              next_zero
);

  localparam int ND = word_width(MIN_DIGITS) / 4;

  logic       carry;
  bcd_digit_t d;

  // NOTE: combinational blocks use blocking '=' so each digit sees the carry
  // produced by the digit below it within the same evaluation; registers use '<='.
  always_comb begin
    next_value = value;
    carry      = 1'b1;
    d          = '0;
    for (int i = 0; i < ND; i++) begin
      d = value[4*i +: 4];
      if (carry) begin
        if (down) begin
          if (d == 4'd0) begin
            d = digit_limit(i);
          end else begin
            d     = d - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == digit_limit(i)) begin
            d = 4'd0;
          end else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end
      end
      next_value[4*i +: 4] = d;
    end
  end

  assign wrap      = carry;
  assign next_zero = (next_value == '0);

endmodule

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch with up/down modes, sticky expired/overflow flags and a
// circular lap store; all state lives here, the BCD arithmetic is in sw_bcd_chain.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int MIN_DIGITS = 2,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              key_start,
  input  logic                              key_lap,
  input  logic                              key_clear,
  input  logic                              count_down,
  input  logic [word_width(MIN_DIGITS)-1:0] preset_bcd,
  input  logic [$clog2(LAP_DEPTH)-1:0]      lap_sel,
  output logic [word_width(MIN_DIGITS)-1:0] time_bcd,
  output logic                              running,
  output logic                              expired,
  output logic                              overflow,
  output logic [word_width(MIN_DIGITS)-1:0] lap_bcd,
  output logic [$clog2(LAP_DEPTH):0]        lap_count
);

  localparam int W   = word_width(MIN_DIGITS);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW  = $clog2(LAP_DEPTH);
  localparam int CW  = LW + 1;

  logic [PW-1:0] prescaler;
  logic          mode_down;
  logic          tick;
  logic          run_next;
  logic [W-1:0]  step_bcd;
  logic          step_wrap;
  logic          step_zero;

  logic [W-1:0]  lap_mem [LAP_DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_idx;
  logic          lap_hit;

  sw_bcd_chain #(.MIN_DIGITS(MIN_DIGITS)) u_chain (
    .value      (time_bcd),
    .down       (mode_down),
    .next_value (step_bcd),
    .wrap       (step_wrap),
    .next_zero  (step_zero)
  );

  assign tick = running && (prescaler == PW'(DIV - 1));

  // NOTE: run_next gets its default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    run_next = running;
    if (key_start) begin
      if (running)                             run_next = 1'b0;
      else if (!(mode_down && time_bcd == '0)) run_next = 1'b1;
    end
    if (tick && mode_down && step_zero) run_next = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      time_bcd  <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      overflow  <= 1'b0;
      mode_down <= 1'b0;
      prescaler <= '0;
    end else if (key_clear) begin
      time_bcd  <= count_down ? preset_bcd : '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      overflow  <= 1'b0;
      mode_down <= count_down;
      prescaler <= '0;
    end else begin
      running <= run_next;
      if (running) prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        time_bcd <= step_bcd;
        if (!mode_down && step_wrap) overflow <= 1'b1;
        if (mode_down && step_zero)  expired  <= 1'b1;
      end
    end
  end

  // Most recent lap sits just behind the write pointer.
  assign rd_idx  = wr_ptr - LW'(1) - lap_sel;
  assign lap_hit = ({1'b0, lap_sel} < lap_count);

  // NOTE: the lap entries are cleared on reset because stale laps must never
  // be observable after power-up; key_clear only empties them logically.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
      lap_bcd   <= '0;
    end else begin
      lap_bcd <= lap_hit ? lap_mem[rd_idx] : '0;
      if (key_clear) begin
        wr_ptr    <= '0;
        lap_count <= '0;
      end else if (key_lap) begin
        lap_mem[wr_ptr] <= time_bcd;
        wr_ptr          <= wr_ptr + LW'(1);
        if (lap_count != CW'(LAP_DEPTH)) lap_count <= lap_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at CLK_HZ=1000, TICK_HZ=100 (one tick per 10 clocks).
module tb_stopwatch_core;

  localparam int W = 24;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          key_start, key_lap, key_clear, count_down;
  logic [W-1:0]  preset_bcd;
  logic [1:0]    lap_sel;
  logic [W-1:0]  time_bcd, lap_bcd;
  logic          running, expired, overflow;
  logic [2:0]    lap_count;

  int checks = 0;
  int errors = 0;

  stopwatch_core #(
    .CLK_HZ(1000), .TICK_HZ(100), .MIN_DIGITS(2), .LAP_DEPTH(4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_start  (key_start),
    .key_lap    (key_lap),
    .key_clear  (key_clear),
    .count_down (count_down),
    .preset_bcd (preset_bcd),
    .lap_sel    (lap_sel),
    .time_bcd   (time_bcd),
    .running    (running),
    .expired    (expired),
    .overflow   (overflow),
    .lap_bcd    (lap_bcd),
    .lap_count  (lap_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic         k_start;
    logic         k_lap;
    logic         k_clear;
    logic         cdown;
    logic [W-1:0] preset;
    logic [1:0]   sel;
    int           idle;
    logic [W-1:0] e_time;
    logic         e_run;
    logic         e_exp;
    logic         e_ov;
    logic [2:0]   e_cnt;
    logic [W-1:0] e_lap;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Keys are held for exactly one rising edge; the bench returns on the next falling edge.
  task automatic keys(input logic s, input logic l, input logic c);
    key_start = s;
    key_lap   = l;
    key_clear = c;
    @(negedge sys_clk);
    key_start = 1'b0;
    key_lap   = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // start, lap, clear, cdown, preset, sel, idle, time, run, exp, ov, cnt, lap
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h0,   2'd0, 0,   24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,   2'd0, 250, 24'h000025, 1'b1, 1'b0, 1'b0, 3'd0, 24'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,   2'd0, 0,   24'h000025, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h0,   2'd0, 1,   24'h000025, 1'b0, 1'b0, 1'b0, 3'd1, 24'h25};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,   2'd0, 9,   24'h000026, 1'b1, 1'b0, 1'b0, 3'd1, 24'h25};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h0,   2'd0, 1,   24'h000026, 1'b0, 1'b0, 1'b0, 3'd2, 24'h26};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h0,   2'd1, 0,   24'h000026, 1'b0, 1'b0, 1'b0, 3'd2, 24'h25};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0,   2'd0, 9,   24'h000027, 1'b1, 1'b0, 1'b0, 3'd2, 24'h26};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h777, 2'd0, 1,   24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0};

    sys_rst    = 1'b1;
    key_start  = 1'b0;
    key_lap    = 1'b0;
    key_clear  = 1'b0;
    count_down = 1'b0;
    preset_bcd = '0;
    lap_sel    = '0;
    idle(2);
    check("reset time", time_bcd, 0);
    check("reset running", running, 0);
    check("reset expired", expired, 0);
    check("reset overflow", overflow, 0);
    check("reset lap_count", lap_count, 0);
    check("reset lap_bcd", lap_bcd, 0);
    sys_rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      count_down = vecs[i].cdown;
      preset_bcd = vecs[i].preset;
      lap_sel    = vecs[i].sel;
      keys(vecs[i].k_start, vecs[i].k_lap, vecs[i].k_clear);
      idle(vecs[i].idle);
      check($sformatf("v%0d time", i), time_bcd, vecs[i].e_time);
      check($sformatf("v%0d running", i), running, vecs[i].e_run);
      check($sformatf("v%0d expired", i), expired, vecs[i].e_exp);
      check($sformatf("v%0d overflow", i), overflow, vecs[i].e_ov);
      check($sformatf("v%0d lap_count", i), lap_count, vecs[i].e_cnt);
      check($sformatf("v%0d lap_bcd", i), lap_bcd, vecs[i].e_lap);
    end

    // Five laps at 1..5 cs into a four-entry store: oldest is overwritten.
    count_down = 1'b0;
    lap_sel    = '0;
    keys(1'b1, 1'b0, 1'b0);
    idle(10);
    for (int k = 1; k <= 5; k++) begin
      keys(1'b0, 1'b1, 1'b0);
      idle(9);
    end
    check("laps time", time_bcd, 24'h000006);
    keys(1'b1, 1'b0, 1'b0);
    check("laps lap_count", lap_count, 4);
    for (int s = 0; s < 4; s++) begin
      lap_sel = 2'(s);
      idle(1);
      check($sformatf("lap sel%0d", s), lap_bcd, 32'(5 - s));
    end
    lap_sel = 2'd3;
    keys(1'b0, 1'b0, 1'b1);
    idle(1);
    check("cleared lap_count", lap_count, 0);
    check("cleared lap_bcd", lap_bcd, 0);

    // Lap on the same edge as a tick keeps the pre-tick time.
    lap_sel = '0;
    keys(1'b1, 1'b0, 1'b0);
    idle(19);
    keys(1'b0, 1'b1, 1'b0);
    idle(1);
    check("lap+tick stored", lap_bcd, 24'h000001);
    check("lap+tick time", time_bcd, 24'h000002);
    check("lap+tick lap_count", lap_count, 1);
    keys(1'b0, 1'b0, 1'b1);

    // Count-up wrap from 99:59.99.
    @(negedge sys_clk);
    force dut.time_bcd = 24'h995999;
    @(negedge sys_clk);
    release dut.time_bcd;
    keys(1'b1, 1'b0, 1'b0);
    idle(10);
    check("wrap time", time_bcd, 24'h000000);
    check("wrap overflow", overflow, 1);
    check("wrap running", running, 1);
    idle(10);
    check("wrap sticky overflow", overflow, 1);
    check("wrap next time", time_bcd, 24'h000001);

    // Countdown from 00:00.03 to zero.
    count_down = 1'b1;
    preset_bcd = 24'h000003;
    keys(1'b0, 1'b0, 1'b1);
    check("down preset", time_bcd, 24'h000003);
    check("down cleared overflow", overflow, 0);
    keys(1'b1, 1'b0, 1'b0);
    idle(29);
    check("down t29 time", time_bcd, 24'h000001);
    check("down t29 running", running, 1);
    check("down t29 expired", expired, 0);
    idle(1);
    check("down t30 time", time_bcd, 24'h000000);
    check("down t30 running", running, 0);
    check("down t30 expired", expired, 1);
    keys(1'b1, 1'b0, 1'b0);
    idle(1);
    check("down restart ignored", running, 0);
    check("down expired sticky", expired, 1);

    // Countdown with second borrow to 00:12.34, then reset mid-count.
    preset_bcd = 24'h001300;
    keys(1'b0, 1'b0, 1'b1);
    check("reload expired", expired, 0);
    keys(1'b1, 1'b0, 1'b0);
    idle(660);
    check("borrow time", time_bcd, 24'h001234);
    keys(1'b0, 1'b1, 1'b0);
    idle(1);
    check("pre-reset lap_count", lap_count, 1);
    check("pre-reset lap_bcd", lap_bcd, 24'h001234);
    sys_rst   = 1'b1;
    key_start = 1'b1;
    key_lap   = 1'b1;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    key_start = 1'b0;
    key_lap   = 1'b0;
    check("rst time", time_bcd, 0);
    check("rst running", running, 0);
    check("rst expired", expired, 0);
    check("rst overflow", overflow, 0);
    check("rst lap_count", lap_count, 0);
    check("rst lap_bcd", lap_bcd, 0);
    // Mode returns to up even though count_down is still high.
    keys(1'b1, 1'b0, 1'b0);
    idle(10);
    check("post-rst up mode", time_bcd, 24'h000001);
    check("post-rst running", running, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
